// File: rtl/moments_pkg.sv
// Shared types and elaboration-time helpers for the image-moment engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, ceil-log2 helper, coordinate-width helper and
// default configuration constants used as parameter defaults by the top.
package moments_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Bits needed to hold a counter running 0..n-1 (never narrower than 1).
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    localparam int DEF_PPW   = 8;
    localparam int DEF_WPR   = 80;
    localparam int DEF_ROWS  = 480;
    localparam int DEF_ACC_W = 32;

endpackage

// File: rtl/moments_popcnt_tree.sv
// Pipelined popcount and set-bit index sum of one PPW-bit beat, with coordinate sideband.
// Latency: TL = log2(PPW) cycles from in_* to out_*.
// Backpressure: none; a beat enters every cycle in_vld is high, clr empties the pipe.
//
// Ports: clk/nrst (async active-low) / clr (sync clear of every stage);
//        in_vld, in_dat[PPW], in_xw, in_y -> out_vld, out_pc, out_idx, out_xw, out_y.
// Build option CALC_MOMENTS_M1_EN: when undefined the index-sum tree and the
// coordinate sideband are not built and out_idx/out_xw/out_y read 0.
module moments_popcnt_tree
    import moments_pkg::*;
#(
    parameter int PPW  = 8,
    parameter int PCW  = 4,
    parameter int IDXW = 6,
    parameter int XW   = 7,
    parameter int YW   = 9
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            clr,
    input  logic            in_vld,
    input  logic [PPW-1:0]  in_dat,
    input  logic [XW-1:0]   in_xw,
    input  logic [YW-1:0]   in_y,
    output logic            out_vld,
    output logic [PCW-1:0]  out_pc,
    output logic [IDXW-1:0] out_idx,
    output logic [XW-1:0]   out_xw,
    output logic [YW-1:0]   out_y
);

    localparam int TL = clog2(PPW);

    // Heap-ordered binary tree: node n has children 2n and 2n+1, nodes
    // PPW..2*PPW-1 are the (unregistered) leaves, 1..PPW-1 are registered.
    // Every internal node is one flop stage above its children, so the root
    // (node 1) is exactly TL registers deep.
    logic [PCW-1:0] pc_q    [1:PPW-1];
    logic [PCW-1:0] pc_d    [1:PPW-1];
    logic [PCW-1:0] pc_tree [2:2*PPW-1];

    logic           sb_vld_q [TL];
    logic           sb_vld_d [TL];

    always_comb begin
        for (int i = 0; i < PPW; i++) begin
            pc_tree[PPW+i] = {{(PCW-1){1'b0}}, in_dat[i]};
        end
        for (int n = 2; n < PPW; n++) begin
            pc_tree[n] = pc_q[n];
        end
        for (int n = 1; n < PPW; n++) begin
            pc_d[n] = clr ? '0 : (pc_tree[2*n] + pc_tree[2*n+1]);
        end
        sb_vld_d[0] = clr ? 1'b0 : in_vld;
        for (int k = 1; k < TL; k++) begin
            sb_vld_d[k] = clr ? 1'b0 : sb_vld_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int n = 1; n < PPW; n++) begin
                pc_q[n] <= '0;
            end
            for (int k = 0; k < TL; k++) begin
                sb_vld_q[k] <= 1'b0;
            end
        end else begin
            pc_q     <= pc_d;
            sb_vld_q <= sb_vld_d;
        end
    end

    assign out_vld = sb_vld_q[TL-1];
    assign out_pc  = pc_q[1];

`ifdef CALC_MOMENTS_M1_EN
    // Same tree shape, leaves carry the pixel index of each set bit.
    logic [IDXW-1:0] idx_q    [1:PPW-1];
    logic [IDXW-1:0] idx_d    [1:PPW-1];
    logic [IDXW-1:0] idx_tree [2:2*PPW-1];
    logic [XW-1:0]   sb_xw_q  [TL];
    logic [XW-1:0]   sb_xw_d  [TL];
    logic [YW-1:0]   sb_y_q   [TL];
    logic [YW-1:0]   sb_y_d   [TL];

    always_comb begin
        for (int i = 0; i < PPW; i++) begin
            idx_tree[PPW+i] = in_dat[i] ? IDXW'(i) : '0;
        end
        for (int n = 2; n < PPW; n++) begin
            idx_tree[n] = idx_q[n];
        end
        for (int n = 1; n < PPW; n++) begin
            idx_d[n] = clr ? '0 : (idx_tree[2*n] + idx_tree[2*n+1]);
        end
        sb_xw_d[0] = clr ? '0 : in_xw;
        sb_y_d[0]  = clr ? '0 : in_y;
        for (int k = 1; k < TL; k++) begin
            sb_xw_d[k] = clr ? '0 : sb_xw_q[k-1];
            sb_y_d[k]  = clr ? '0 : sb_y_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int n = 1; n < PPW; n++) begin
                idx_q[n] <= '0;
            end
            for (int k = 0; k < TL; k++) begin
                sb_xw_q[k] <= '0;
                sb_y_q[k]  <= '0;
            end
        end else begin
            idx_q   <= idx_d;
            sb_xw_q <= sb_xw_d;
            sb_y_q  <= sb_y_d;
        end
    end

    assign out_idx = idx_q[1];
    assign out_xw  = sb_xw_q[TL-1];
    assign out_y   = sb_y_q[TL-1];
`else
    logic unused_sb;
    assign unused_sb = ^{in_xw, in_y};
    assign out_idx   = '0;
    assign out_xw    = '0;
    assign out_y     = '0;
`endif

endmodule

// File: rtl/calc_moments_pipe.sv
// Streaming binary-image moment engine: m00 (set-pixel count), optional m10/m01 (sum x / sum y).
// Latency: rd_done at cycle T -> m_done pulse with fresh results at cycle T+TL+2 (TL = log2(PPW)).
// Backpressure: none; beats are taken whenever din_vld is high in IDLE/ACC, dropped in FLUSH/DONE.
//
// Ports: clk, nrst (async active-low), clr (sync abort/clear);
//        din_vld/din[PPW] pixel beats, rd_done end-of-frame pulse;
//        m00/m10/m01[ACC_W] held results, m_done result strobe, busy (ACC or FLUSH).
// Build option CALC_MOMENTS_M1_EN: builds the m10/m01 datapath; otherwise those ports read 0.
module calc_moments_pipe
    import moments_pkg::*;
#(
    parameter int PPW   = DEF_PPW,
    parameter int WPR   = DEF_WPR,
    parameter int ROWS  = DEF_ROWS,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             din_vld,
    input  logic [PPW-1:0]   din,
    input  logic             rd_done,
    output logic [ACC_W-1:0] m00,
    output logic [ACC_W-1:0] m10,
    output logic [ACC_W-1:0] m01,
    output logic             m_done,
    output logic             busy
);

    localparam int TL   = clog2(PPW);
    localparam int PCW  = TL + 1;
    localparam int IDXW = 2 * TL;
    localparam int XW   = width_of(WPR);
    localparam int YW   = width_of(ROWS);
    localparam int FCW  = width_of(TL + 1);

    state_t           state_q, state_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic             m_done_q, m_done_d;
    logic [XW-1:0]    xw_q, xw_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ACC_W-1:0] m00_acc_q, m00_acc_d, m00_out_q, m00_out_d, m00_sum;
    logic             beat_acc;

    logic             t_vld;
    logic [PCW-1:0]   t_pc;
    logic [IDXW-1:0]  t_idx;
    logic [XW-1:0]    t_xw;
    logic [YW-1:0]    t_y;

    moments_popcnt_tree #(
        .PPW  (PPW),
        .PCW  (PCW),
        .IDXW (IDXW),
        .XW   (XW),
        .YW   (YW)
    ) u_tree (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (clr),
        .in_vld  (beat_acc),
        .in_dat  (din),
        .in_xw   (xw_q),
        .in_y    (y_q),
        .out_vld (t_vld),
        .out_pc  (t_pc),
        .out_idx (t_idx),
        .out_xw  (t_xw),
        .out_y   (t_y)
    );

`ifdef CALC_MOMENTS_M1_EN
    logic [ACC_W-1:0] m10_acc_q, m10_acc_d, m10_out_q, m10_out_d, m10_sum;
    logic [ACC_W-1:0] m01_acc_q, m01_acc_d, m01_out_q, m01_out_d, m01_sum;
`else
    logic unused_m1;
    assign unused_m1 = ^{t_idx, t_xw, t_y};
`endif

    always_comb begin
        beat_acc = din_vld && ((state_q == IDLE) || (state_q == ACC));

        m00_sum = m00_acc_q + (t_vld ? ACC_W'(t_pc) : '0);
`ifdef CALC_MOMENTS_M1_EN
        // x of bit i is xw*PPW + i, so a beat contributes pc*xw*PPW + sum(i).
        m10_sum = m10_acc_q + (t_vld ? (ACC_W'(t_pc) * (ACC_W'(t_xw) << TL) + ACC_W'(t_idx)) : '0);
        m01_sum = m01_acc_q + (t_vld ? (ACC_W'(t_pc) * ACC_W'(t_y)) : '0);
        m10_acc_d = m10_sum;
        m01_acc_d = m01_sum;
        m10_out_d = m10_out_q;
        m01_out_d = m01_out_q;
`endif
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        m_done_d    = 1'b0;
        m00_acc_d   = m00_sum;
        m00_out_d   = m00_out_q;
        xw_d        = xw_q;
        y_d         = y_q;

        // Coordinates of the accepted beat; rows past ROWS-1 wrap silently.
        if (beat_acc) begin
            if (xw_q == XW'(WPR - 1)) begin
                xw_d = '0;
                y_d  = (y_q == YW'(ROWS - 1)) ? '0 : (y_q + 1'b1);
            end else begin
                xw_d = xw_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rd_done) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (beat_acc) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (rd_done) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                // TL+1 cycles drains the tree and the accumulate stage; results
                // are latched on the edge into DONE so they appear with m_done.
                if (flush_cnt_q == FCW'(TL)) begin
                    state_d   = DONE;
                    m_done_d  = 1'b1;
                    m00_out_d = m00_sum;
                    m00_acc_d = '0;
                    xw_d      = '0;
                    y_d       = '0;
`ifdef CALC_MOMENTS_M1_EN
                    m10_out_d = m10_sum;
                    m01_out_d = m01_sum;
                    m10_acc_d = '0;
                    m01_acc_d = '0;
`endif
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            state_d     = IDLE;
            flush_cnt_d = '0;
            m_done_d    = 1'b0;
            m00_acc_d   = '0;
            m00_out_d   = '0;
            xw_d        = '0;
            y_d         = '0;
`ifdef CALC_MOMENTS_M1_EN
            m10_acc_d = '0;
            m01_acc_d = '0;
            m10_out_d = '0;
            m01_out_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            m_done_q    <= 1'b0;
            m00_acc_q   <= '0;
            m00_out_q   <= '0;
            xw_q        <= '0;
            y_q         <= '0;
`ifdef CALC_MOMENTS_M1_EN
            m10_acc_q <= '0;
            m01_acc_q <= '0;
            m10_out_q <= '0;
            m01_out_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            m_done_q    <= m_done_d;
            m00_acc_q   <= m00_acc_d;
            m00_out_q   <= m00_out_d;
            xw_q        <= xw_d;
            y_q         <= y_d;
`ifdef CALC_MOMENTS_M1_EN
            m10_acc_q <= m10_acc_d;
            m01_acc_q <= m01_acc_d;
            m10_out_q <= m10_out_d;
            m01_out_q <= m01_out_d;
`endif
        end
    end

    assign m00    = m00_out_q;
    assign m_done = m_done_q;
    assign busy   = (state_q == ACC) || (state_q == FLUSH);
`ifdef CALC_MOMENTS_M1_EN
    assign m10 = m10_out_q;
    assign m01 = m01_out_q;
`else
    assign m10 = '0;
    assign m01 = '0;
`endif

endmodule

// File: tb/tb_calc_moments_pipe.sv
// Bench for calc_moments_pipe with PPW=8, WPR=2, ROWS=2, ACC_W=32.
// Expected moments come from a per-pixel reference: beat k of a frame sits at
// xw = k mod WPR, y = (k / WPR) mod ROWS, and each set bit i adds x = xw*PPW+i.
module tb_calc_moments_pipe;

    localparam int PPW   = 8;
    localparam int WPR   = 2;
    localparam int ROWS  = 2;
    localparam int ACC_W = 32;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              clr = 1'b0;
    logic              din_vld = 1'b0;
    logic [PPW-1:0]    din = '0;
    logic              rd_done = 1'b0;
    logic [ACC_W-1:0]  m00, m10, m01;
    logic              m_done, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: running frame sums and the values the outputs must hold.
    int unsigned e00 = 0, e10 = 0, e01 = 0;
    int unsigned bk = 0;
    int unsigned o00 = 0, o10 = 0, o01 = 0;

    calc_moments_pipe #(
        .PPW   (PPW),
        .WPR   (WPR),
        .ROWS  (ROWS),
        .ACC_W (ACC_W)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (clr),
        .din_vld (din_vld),
        .din     (din),
        .rd_done (rd_done),
        .m00     (m00),
        .m10     (m10),
        .m01     (m01),
        .m_done  (m_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_m00"}, m00, o00);
`ifdef CALC_MOMENTS_M1_EN
        chk({tag, "_m10"}, m10, o10);
        chk({tag, "_m01"}, m01, o01);
`else
        chk({tag, "_m10"}, m10, 32'd0);
        chk({tag, "_m01"}, m01, 32'd0);
`endif
    endtask

    task automatic model_add(input logic [PPW-1:0] b);
        int unsigned xw;
        int unsigned y;
        xw = bk % WPR;
        y  = (bk / WPR) % ROWS;
        for (int i = 0; i < PPW; i++) begin
            if (b[i]) begin
                e00 = e00 + 1;
                e10 = e10 + xw * PPW + i;
                e01 = e01 + y;
            end
        end
        bk = bk + 1;
    endtask

    task automatic model_clear();
        e00 = 0; e10 = 0; e01 = 0; bk = 0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        din_vld = 1'b0; rd_done = 1'b0; clr = 1'b0;
    endtask

    task automatic send(input logic [PPW-1:0] b);
        @(posedge clk); #1;
        din_vld = 1'b1; din = b; rd_done = 1'b0;
        model_add(b);
    endtask

    // rd_done in cycle T (optionally with a final beat); checks m_done/busy/outputs
    // for T+1..T+6. With junk set, random beats and rd_done are thrown at FLUSH/DONE.
    task automatic end_frame(input string tag, input bit with_beat, input logic [PPW-1:0] b, input bit junk);
        @(posedge clk); #1;
        rd_done = 1'b1; din_vld = with_beat; din = b;
        if (with_beat) model_add(b);
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            rd_done = 1'b0; din_vld = 1'b0; din = PPW'($urandom);
            if (junk && j <= 5) begin
                rd_done = 1'($urandom_range(0, 1));
                din_vld = 1'($urandom_range(0, 1));
            end
            if (j == 5) begin
                o00 = e00; o10 = e10; o01 = e01;
                model_clear();
            end
            @(negedge clk);
            chk1({tag, "_m_done"}, m_done, (j == 5));
            chk1({tag, "_busy"}, busy, (j < 5));
            chk_outs(tag);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk1("rst_m_done", m_done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk_outs("rst");
        @(posedge clk); #1;
        nrst = 1'b1;

        // Full frame of set pixels
        for (int k = 0; k < 3; k++) send(8'hFF);
        end_frame("full", 1'b1, 8'hFF, 1'b0);
        chk("full_m00_abs", m00, 32'd32);
`ifdef CALC_MOMENTS_M1_EN
        chk("full_m10_abs", m10, 32'd240);
        chk("full_m01_abs", m01, 32'd16);
`endif

        // Empty frame straight from IDLE
        idle_cycle();
        end_frame("empty", 1'b0, 8'h00, 1'b0);
        chk("empty_m00_abs", m00, 32'd0);

        // Single pixel at x=15, y=1
        for (int k = 0; k < 3; k++) send(8'h00);
        end_frame("last_px", 1'b1, 8'h80, 1'b0);
        chk("last_px_m00_abs", m00, 32'd1);
`ifdef CALC_MOMENTS_M1_EN
        chk("last_px_m10_abs", m10, 32'd15);
        chk("last_px_m01_abs", m01, 32'd1);
`endif

        // clr while flushing: no m_done, everything cleared
        for (int k = 0; k < 4; k++) send(8'hFF);
        @(posedge clk); #1; din_vld = 1'b0; rd_done = 1'b1;
        @(posedge clk); #1; rd_done = 1'b0;
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        model_clear();
        o00 = 0; o10 = 0; o01 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk1("clr_m_done", m_done, 1'b0);
            chk1("clr_busy", busy, 1'b0);
            chk_outs("clr");
        end
        for (int k = 0; k < 3; k++) send(8'h01);
        end_frame("after_clr", 1'b1, 8'h01, 1'b0);
        chk("after_clr_m00_abs", m00, 32'd4);
`ifdef CALC_MOMENTS_M1_EN
        chk("after_clr_m10_abs", m10, 32'd16);
        chk("after_clr_m01_abs", m01, 32'd2);
`endif

        // Back-to-back frames: second must not inherit the first
        for (int k = 0; k < 3; k++) send(8'hFF);
        end_frame("b2b_a", 1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) send(8'h0F);
        end_frame("b2b_b", 1'b1, 8'h0F, 1'b0);
        chk("b2b_m00_abs", m00, 32'd16);

        // Asynchronous reset mid-frame
        send(8'hAA);
        send(8'h55);
        @(posedge clk); #3;
        din_vld = 1'b0;
        nrst = 1'b0;
        #1;
        model_clear();
        o00 = 0; o10 = 0; o01 = 0;
        chk1("nrst_m_done", m_done, 1'b0);
        chk1("nrst_busy", busy, 1'b0);
        chk_outs("nrst");
        @(posedge clk); #1; nrst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk1("post_nrst_m_done", m_done, 1'b0);
            chk_outs("post_nrst");
            @(posedge clk); #1;
        end

        // Random frames: 0..6 beats (row wrap included), idle gaps, beat on the
        // rd_done cycle, and stray beats/rd_done during FLUSH/DONE.
        for (int f = 0; f < 25; f++) begin
            int nb;
            nb = $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 2) == 0) idle_cycle();
                send(PPW'($urandom));
            end
            end_frame("rand", 1'($urandom_range(0, 1)), PPW'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
